// File: rtl/pixel_buffer_responder.sv
// Single-beat pixel read/write responder over an 8-bit-per-pixel frame store,
// with an independent one-cycle scan-out read port for the VGA path.
module pixel_buffer_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0800_0000,
    parameter int          WIDTH     = 640,
    parameter int          HEIGHT    = 480,
    parameter int          X_SHIFT   = 10,
    parameter int          Y_BITS    = 9
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [31:0]        address,
    input  logic [3:0]         byte_enable,
    input  logic               read,
    input  logic               write,
    input  logic [31:0]        write_data,
    output logic               acknowledge,
    output logic [31:0]        read_data,
    output logic               oob_error,
    input  logic [X_SHIFT-1:0] scan_x,
    input  logic [Y_BITS-1:0]  scan_y,
    output logic [7:0]         scan_pixel
);

    localparam int                  DEPTH    = WIDTH * HEIGHT;
    localparam int                  IDX_W    = $clog2(DEPTH);
    localparam logic [X_SHIFT-1:0]  WIDTH_X  = X_SHIFT'(WIDTH);
    localparam logic [Y_BITS-1:0]   HEIGHT_Y = Y_BITS'(HEIGHT);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK,
        RELEASE
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0]       mem [DEPTH];

    logic             is_write_p1;
    logic             be_p1;
    logic             in_win_p1;
    logic [7:0]       wdata_p1;
    logic [IDX_W-1:0] idx_p1;
    logic [7:0]       rd_pixel_p2;

    logic             mem_we;
    logic             scan_in;
    logic [IDX_W-1:0] scan_idx;
    logic [31:0]      req_offset;
    logic             unused_bits;

    function automatic logic [IDX_W-1:0] pixel_index(input logic [X_SHIFT-1:0] x,
                                                     input logic [Y_BITS-1:0]  y);
        return IDX_W'(y) * IDX_W'(WIDTH) + IDX_W'(x);
    endfunction

    function automatic logic in_window(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return (addr >= BASE_ADDR)
            && (off[31:X_SHIFT+Y_BITS] == '0)
            && (off[X_SHIFT-1:0] < WIDTH_X)
            && (off[X_SHIFT+Y_BITS-1:X_SHIFT] < HEIGHT_Y);
    endfunction

    assign unused_bits = ^{byte_enable[3:1], write_data[31:8]};
    assign req_offset  = address - BASE_ADDR;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // RELEASE swallows a request still held from the acknowledged transaction.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (read || write) state_next = ACCESS;
            ACCESS:  state_next = ACK;
            ACK:     state_next = RELEASE;
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // p1: request captured in IDLE; a simultaneous read+write is a write.
    always_ff @(posedge clock) begin
        if (state == IDLE && (read || write)) begin
            is_write_p1 <= write;
            be_p1       <= byte_enable[0];
            wdata_p1    <= write_data[7:0];
            in_win_p1   <= in_window(address);
            idx_p1      <= pixel_index(req_offset[X_SHIFT-1:0],
                                       req_offset[X_SHIFT+Y_BITS-1:X_SHIFT]);
        end
    end

    // p2: memory access in ACCESS; a reset sampled here cancels the commit.
    assign mem_we = (state == ACCESS) && is_write_p1 && in_win_p1 && be_p1 && !reset;

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[idx_p1] <= wdata_p1;
        end
        if (state == ACCESS) begin
            rd_pixel_p2 <= mem[idx_p1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acknowledge <= 1'b0;
            read_data   <= '0;
            oob_error   <= 1'b0;
        end else begin
            acknowledge <= (state == ACK);
            if (state == ACK) begin
                read_data <= (!is_write_p1 && in_win_p1) ? {24'b0, rd_pixel_p2} : '0;
            end
            if (state == ACCESS && !in_win_p1) begin
                oob_error <= 1'b1;
            end
        end
    end

    // Scan port: separate read, old data wins against a same-edge write.
    assign scan_in  = (scan_x < WIDTH_X) && (scan_y < HEIGHT_Y);
    assign scan_idx = pixel_index(scan_x, scan_y);

    always_ff @(posedge clock) begin
        if (reset) begin
            scan_pixel <= '0;
        end else begin
            scan_pixel <= scan_in ? mem[scan_idx] : 8'h00;
        end
    end

endmodule
